// File: rtl/tse_cfg_sequencer.sv
// rtl/tse_cfg_sequencer.sv - AHB-Lite master that walks a config table of WRITE/POLL/WAIT/END entries
module tse_cfg_sequencer #(
   parameter int NUM_ENTRIES = 16,
   parameter int POLL_LIMIT  = 1023,
   parameter int IDX_W       = 4
) (
   input  logic             i_hclk,
   input  logic             i_hreset,
   input  logic             i_start,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [1:0]       o_err_code,
   output logic [IDX_W-1:0] o_err_index,
   output logic [IDX_W-1:0] o_tbl_addr,
   input  logic [41:0]      i_tbl_data,
   output logic [7:0]       o_haddr,
   output logic [1:0]       o_htrans,
   output logic             o_hwrite,
   output logic [2:0]       o_hsize,
   output logic [31:0]      o_hwdata,
   input  logic [31:0]      i_hrdata,
   input  logic             i_hready,
   input  logic [1:0]       i_hresp
);

   localparam int         PC_W     = $clog2(POLL_LIMIT + 1);
   localparam logic [1:0] OP_END   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [1:0] OP_WAIT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ADDR, S_DATA, S_GAP, S_WAIT, S_FIN
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [IDX_W-1:0]  r_tbl_addr;
   logic [31:0]       r_data;
   logic [7:0]        r_haddr;
   logic              r_hwrite;
   logic [31:0]       r_hwdata;
   logic [PC_W-1:0]   r_poll_cnt;
   logic [15:0]       r_wait_cnt;
   logic              r_done;
   logic              r_error;
   logic [1:0]        r_err_code;
   logic [IDX_W-1:0]  r_err_index;

   logic [1:0]        w_op;
   logic              w_last;
   logic              w_bus_err;
   logic              w_poll_ok;
   logic [PC_W-1:0]   w_poll_inc;
   logic              w_poll_to;
   logic              w_advance;

   assign w_op       = i_tbl_data[41:40];
   assign w_last     = (r_tbl_addr == IDX_W'(NUM_ENTRIES - 1));
   assign w_bus_err  = (i_hresp == 2'b01);
   assign w_poll_ok  = ((i_hrdata & r_data) == 32'd0);
   assign w_poll_inc = r_poll_cnt + PC_W'(1);
   assign w_poll_to  = (w_poll_inc == PC_W'(POLL_LIMIT));

   // Every path that finishes an entry funnels through here, including a zero-length WAIT.
   assign w_advance = ((r_state == S_DECODE) && (w_op == OP_WAIT) && (i_tbl_data[15:0] == 16'd0))
                   || ((r_state == S_DATA) && !w_bus_err && i_hready && (r_hwrite || w_poll_ok))
                   || ((r_state == S_WAIT) && (r_wait_cnt == 16'd0));

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (w_op)
               OP_END:           w_next = S_FIN;
               OP_WRITE, OP_POLL: w_next = S_ADDR;
               default:          w_next = S_WAIT;
            endcase
         end
         S_ADDR:   if (i_hready) w_next = S_DATA;
         S_DATA: begin
            if (w_bus_err)
               w_next = S_FIN;
            else if (i_hready && !r_hwrite && !w_poll_ok)
               w_next = w_poll_to ? S_FIN : S_GAP;
         end
         S_GAP:    w_next = S_ADDR;
         S_WAIT:   w_next = S_WAIT;
         S_FIN:    w_next = S_IDLE;
      endcase
      if (w_advance) w_next = w_last ? S_FIN : S_FETCH;
   end

   // Address phase is exactly the ADDR state, so an async reset drops NONSEQ at once.
   always_comb begin
      o_htrans = (r_state == S_ADDR) ? 2'b10 : 2'b00;
      o_busy   = (r_state != S_IDLE) && (r_state != S_FIN);
   end

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset) begin
         r_tbl_addr  <= '0;
         r_data      <= '0;
         r_haddr     <= '0;
         r_hwrite    <= 1'b0;
         r_hwdata    <= '0;
         r_poll_cnt  <= '0;
         r_wait_cnt  <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= 2'b00;
         r_err_index <= '0;
      end else begin
         if ((r_state == S_IDLE) && i_start) begin
            r_tbl_addr <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
         end
         if (r_state == S_DECODE) begin
            r_data     <= i_tbl_data[31:0];
            r_poll_cnt <= '0;
            if ((w_op == OP_WRITE) || (w_op == OP_POLL)) begin
               r_haddr  <= i_tbl_data[39:32];
               r_hwrite <= (w_op == OP_WRITE);
            end
            if (w_op == OP_WAIT) r_wait_cnt <= i_tbl_data[15:0];
            if (w_op == OP_END)  r_done     <= 1'b1;
         end
         if ((r_state == S_ADDR) && i_hready && r_hwrite) r_hwdata <= r_data;
         if (r_state == S_DATA) begin
            if (w_bus_err) begin
               r_error     <= 1'b1;
               r_err_code  <= 2'b01;
               r_err_index <= r_tbl_addr;
            end else if (i_hready && !r_hwrite && !w_poll_ok) begin
               r_poll_cnt <= w_poll_inc;
               if (w_poll_to) begin
                  r_error     <= 1'b1;
                  r_err_code  <= 2'b10;
                  r_err_index <= r_tbl_addr;
               end
            end
         end
         if ((r_state == S_WAIT) && (r_wait_cnt != 16'd0)) r_wait_cnt <= r_wait_cnt - 16'd1;
         if (w_advance) begin
            if (w_last) begin
               r_error     <= 1'b1;
               r_err_code  <= 2'b11;
               r_err_index <= r_tbl_addr;
            end else begin
               r_tbl_addr <= r_tbl_addr + IDX_W'(1);
            end
         end
      end
   end

   assign o_done      = r_done;
   assign o_error     = r_error;
   assign o_err_code  = r_err_code;
   assign o_err_index = r_err_index;
   assign o_tbl_addr  = r_tbl_addr;
   assign o_haddr     = r_haddr;
   assign o_hwrite    = r_hwrite;
   assign o_hsize     = 3'b010;
   assign o_hwdata    = r_hwdata;

endmodule
